// File: rtl/mem_1r1w_masked_fwd.sv
// Byte-masked 1R1W RAM with write-first forwarding and a registered
// read pipeline of READ_LATENCY stages; lanes are merged at the last stage.
module mem_1r1w_masked_fwd #(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 64,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int MASK_W = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [MASK_W-1:0] W0_mask
);

  if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be in 1..4");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end

  typedef struct packed {
    logic              hit;
    logic [MASK_W-1:0] mask;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  old;
  } rd_t;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic r_in;
  logic w_in;

  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign r_in = 1'b1;
    assign w_in = 1'b1;
  end else begin : g_npow2
    localparam logic [ADDR_W:0] LIM = DEPTH[ADDR_W:0];
    assign r_in = {1'b0, R0_addr} < LIM;
    assign w_in = {1'b0, W0_addr} < LIM;
  end

  rd_t iss;

  // Read-first snapshot; the write's effect is reapplied at the merge.
  always_comb begin
    iss       = '0;
    iss.old   = r_in ? mem_q[R0_addr] : '0;
    iss.hit   = W0_en && w_in && r_in
              && (R0_addr == W0_addr);
    iss.mask  = W0_mask;
    iss.wdata = W0_data;
  end

  always_ff @(posedge clock) begin
    if (W0_en && w_in) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (W0_mask[i]) begin
          mem_q[W0_addr][i*MASK_GRAN +: MASK_GRAN]
            <= W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  rd_t                    st_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= R0_en;
      if (R0_en) begin
        st_q[0] <= iss;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          st_q[k] <= st_q[k-1];
        end
      end
    end
  end

  rd_t              last;
  logic [WIDTH-1:0] lane_m;

  assign last = st_q[READ_LATENCY-1];

  always_comb begin
    lane_m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      lane_m[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{last.mask[i]}};
    end
  end

  assign R0_data  = last.hit
                  ? ((last.wdata & lane_m) | (last.old & ~lane_m))
                  : last.old;
  assign R0_valid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_1r1w_masked_fwd.sv
// Directed bench for mem_1r1w_masked_fwd: four configurations share one
// input bus; each test checks the instance it targets.
module tb_mem_1r1w_masked_fwd;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  ra = '0;
  logic [4:0]  wa = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [63:0] wd = '0;
  logic [7:0]  wm = '0;

  logic        v1, v3, vd, v4;
  logic [63:0] d1, d3, dd, d4;

  logic [63:0] ref_m [32];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_1r1w_masked_fwd #(.DEPTH(32), .READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(ra), .R0_en(re), .R0_data(d1), .R0_valid(v1),
    .W0_addr(wa), .W0_en(we), .W0_data(wd), .W0_mask(wm));

  mem_1r1w_masked_fwd #(.DEPTH(32), .READ_LATENCY(3)) u_l3 (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(ra), .R0_en(re), .R0_data(d3), .R0_valid(v3),
    .W0_addr(wa), .W0_en(we), .W0_data(wd), .W0_mask(wm));

  mem_1r1w_masked_fwd #(.DEPTH(20), .READ_LATENCY(1)) u_d20 (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(ra), .R0_en(re), .R0_data(dd), .R0_valid(vd),
    .W0_addr(wa), .W0_en(we), .W0_data(wd), .W0_mask(wm));

  mem_1r1w_masked_fwd #(.DEPTH(32), .READ_LATENCY(4)) u_l4 (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(ra), .R0_en(re), .R0_data(d4), .R0_valid(v4),
    .W0_addr(wa), .W0_en(we), .W0_data(wd), .W0_mask(wm));

  function automatic logic [63:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {24'hC0FFEE, b, 24'h5A5A5A, ~b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ref_write(input int a, input logic [63:0] d,
                           input logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) ref_m[a][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (v1 !== 1'b0 || d1 !== 64'h0) begin
      errors++;
      $display("FAIL reset_l1: valid=%b data=%h, want 0/0", v1, d1);
    end
    checks++;
    if (v4 !== 1'b0 || d4 !== 64'h0 || v3 !== 1'b0 || vd !== 1'b0) begin
      errors++;
      $display("FAIL reset_other: v3=%b vd=%b v4=%b d4=%h, want 0",
               v3, vd, v4, d4);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int a = 0; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wd = pat(a); wm = 8'hFF;
      tick();
      ref_write(a, pat(a), 8'hFF);
    end
    we = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd3; wd = 64'h0123_4567_89AB_CDEF; wm = 8'hFF;
    tick();
    ref_write(3, 64'h0123_4567_89AB_CDEF, 8'hFF);
    we = 1'b0; re = 1'b1; ra = 5'd3;
    tick();
    re = 1'b0;
    checks++;
    if (v1 !== 1'b1 || d1 !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL write_read: valid=%b data=%h, want 1/%h",
               v1, d1, 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_forward();
    re = 1'b1; ra = 5'd3;
    we = 1'b1; wa = 5'd3; wd = 64'hFFFF_FFFF_FFFF_FFFF; wm = 8'h0F;
    tick();
    re = 1'b0; we = 1'b0;
    ref_write(3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    checks++;
    if (v1 !== 1'b1 || d1 !== 64'h0123_4567_FFFF_FFFF) begin
      errors++;
      $display("FAIL forward: valid=%b data=%h, want 1/%h",
               v1, d1, 64'h0123_4567_FFFF_FFFF);
    end
    tick();
    checks++;
    if (v1 !== 1'b0 || d1 !== 64'h0123_4567_FFFF_FFFF) begin
      errors++;
      $display("FAIL idle_hold: valid=%b data=%h, want 0/%h",
               v1, d1, 64'h0123_4567_FFFF_FFFF);
    end
  endtask

  task automatic test_latency3();
    logic [63:0] old5;
    for (int i = 0; i < 4; i++) tick();
    old5 = ref_m[5];
    re = 1'b1; ra = 5'd5;
    tick();
    re = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 64'hDEAD_BEEF_0BAD_F00D; wm = 8'hFF;
    tick();
    we = 1'b0;
    ref_write(5, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    checks++;
    if (v3 !== 1'b0) begin
      errors++;
      $display("FAIL l3_early: valid=%b, want 0", v3);
    end
    re = 1'b1; ra = 5'd5;
    tick();
    re = 1'b0;
    checks++;
    if (v3 !== 1'b1 || d3 !== old5) begin
      errors++;
      $display("FAIL l3_old: valid=%b data=%h, want 1/%h", v3, d3, old5);
    end
    tick();
    checks++;
    if (v3 !== 1'b0 || d3 !== old5) begin
      errors++;
      $display("FAIL l3_gap: valid=%b data=%h, want 0/%h", v3, d3, old5);
    end
    tick();
    checks++;
    if (v3 !== 1'b1 || d3 !== 64'hDEAD_BEEF_0BAD_F00D) begin
      errors++;
      $display("FAIL l3_new: valid=%b data=%h, want 1/%h",
               v3, d3, 64'hDEAD_BEEF_0BAD_F00D);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 34; i++) begin
      re = (i < 32);
      ra = 5'(i);
      tick();
      if (i < 32) begin
        checks++;
        if (v1 !== 1'b1 || d1 !== ref_m[i]) begin
          errors++;
          $display("FAIL b2b_l1[%0d]: valid=%b data=%h, want 1/%h",
                   i, v1, d1, ref_m[i]);
        end
      end
      if (i >= 2) begin
        checks++;
        if (v3 !== 1'b1 || d3 !== ref_m[i-2]) begin
          errors++;
          $display("FAIL b2b_l3[%0d]: valid=%b data=%h, want 1/%h",
                   i - 2, v3, d3, ref_m[i-2]);
        end
      end
    end
    re = 1'b0;
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 4; i++) tick();
    we = 1'b1; wa = 5'd25; wd = 64'h5555_AAAA_5555_AAAA; wm = 8'hFF;
    tick();
    we = 1'b0;
    ref_write(25, 64'h5555_AAAA_5555_AAAA, 8'hFF);
    re = 1'b1; ra = 5'd25;
    tick();
    re = 1'b0;
    checks++;
    if (vd !== 1'b1 || dd !== 64'h0) begin
      errors++;
      $display("FAIL oor_read: valid=%b data=%h, want 1/0", vd, dd);
    end
    checks++;
    if (v1 !== 1'b1 || d1 !== 64'h5555_AAAA_5555_AAAA) begin
      errors++;
      $display("FAIL inrange_25: valid=%b data=%h, want 1/%h",
               v1, d1, 64'h5555_AAAA_5555_AAAA);
    end
    for (int i = 0; i < 20; i++) begin
      re = 1'b1; ra = 5'(i);
      tick();
      checks++;
      if (vd !== 1'b1 || dd !== ref_m[i]) begin
        errors++;
        $display("FAIL d20_keep[%0d]: valid=%b data=%h, want 1/%h",
                 i, vd, dd, ref_m[i]);
      end
    end
    re = 1'b0;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 5; i++) tick();
    for (int i = 7; i < 10; i++) begin
      re = 1'b1; ra = 5'(i);
      tick();
    end
    re = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (v4 !== 1'b0 || d4 !== 64'h0) begin
      errors++;
      $display("FAIL rst_async: valid=%b data=%h, want 0/0", v4, d4);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (v4 !== 1'b0) begin
        errors++;
        $display("FAIL rst_ghost[%0d]: valid=%b, want 0", i, v4);
      end
    end
    re = 1'b1; ra = 5'd7;
    tick();
    re = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (v4 !== 1'b1 || d4 !== ref_m[7]) begin
      errors++;
      $display("FAIL rst_retain: valid=%b data=%h, want 1/%h",
               v4, d4, ref_m[7]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_forward();
    test_latency3();
    test_back_to_back();
    test_out_of_range();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
